mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive data grants allowed while a fetch request waits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req / if_addr[31:0]  input  1/32  instruction-fetch request and byte address.
REQ-005 SHALL have port if_gnt / if_rvalid / if_rdata[31:0]  output  1/1/32  fetch grant, response valid, instruction word.
REQ-006 SHALL have port d_req / d_we / d_funct3[2:0] / d_addr[31:0] / d_wdata[31:0]  input  data request, store flag, RV32 load/store funct3, byte address, store data.
REQ-007 SHALL have port d_gnt / d_rvalid / d_err / d_rdata[31:0]  output  data grant, response valid, misalignment error, extended load data.
REQ-008 SHALL have port mem_en / mem_we / mem_be[3:0] / mem_addr[31:0] / mem_wdata[31:0]  output  single-port memory command; mem_addr[1:0] always 0.
REQ-009 SHALL have port mem_rdata[31:0]  input  memory word, valid in the cycle after mem_en.

Function
REQ-010 SHALL implement FSM states IDLE, RESP_IF, RESP_D; grants are issued only in IDLE; every RESP state returns to IDLE after one cycle (one access per 2 cycles).
REQ-011 In IDLE, a grant cycle SHALL assert the matching gnt, mem_en, and the memory command combinationally; the response (rvalid pulse, 1 cycle) SHALL follow in the next cycle.
REQ-012 Arbitration SHALL be data-priority, except that a fetch is granted when if_req=1 and starve_cnt==STARVE_MAX.
REQ-013 starve_cnt SHALL increment on each data grant while if_req=1, clear on a fetch grant, and clear whenever if_req=0.
REQ-014 Requesters SHALL hold req and payload until gnt; a request dropped before gnt SHALL have no effect.
REQ-015 At grant, the arbiter SHALL register funct3, addr[1:0], and d_we for use in the response cycle.
REQ-016 Loads SHALL decode funct3 as 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; byte lane = addr[1:0]; half lane = addr[1]; lb/lh sign-extend, lbu/lhu zero-extend.
REQ-017 Stores SHALL produce mem_be = 1<<addr[1:0] for sb, 0011/1100 (by addr[1]) for sh, and 1111 for sw; mem_wdata SHALL hold the byte replicated x4 for sb and the half replicated x2 for sh.
REQ-018 Undefined funct3 (011, 110, 111) SHALL be treated as a word access.
REQ-019 Stores SHALL pulse d_rvalid as a completion acknowledgement, with d_rdata=0.
REQ-020 A fetch SHALL ignore if_addr[1:0], read with mem_be=1111, and return mem_rdata unmodified.
REQ-021 When both requests are idle, all mem_* outputs SHALL be 0.

Reset
REQ-022 Reset SHALL force state IDLE, starve_cnt 0, and all outputs 0.
REQ-023 Reset asserted during RESP_* SHALL drop the pending response, so no rvalid follows.

Configuration
REQ-024 With MISALIGN_CHK_EN defined, a misaligned access (lh/lhu/sh with addr[0]=1; lw/sw/undefined funct3 with addr[1:0]!=0) SHALL be granted without asserting mem_en and answered next cycle with d_rvalid=1, d_err=1, d_rdata=0.
REQ-025 Without MISALIGN_CHK_EN, misaligned accesses SHALL proceed using the lane rules above, and d_err SHALL be constant 0.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the state enum and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-027 Lane extraction, extension, byte-enable, and write replication SHALL live in a combinational sub-module named ls_align.

Verification
REQ-028 Load test: with word 4 = 32'h8040F0FF, the bench SHALL check:
- lb @4 -> FFFFFFFF
- lbu @4 -> 000000FF
- lh @4 -> FFFFF0FF
- lhu @4 -> 0000F0FF
- lw @4 -> 8040F0FF
- lb @7 -> FFFFFF80
REQ-029 Store test: sb @6 with wdata 0x000000AB SHALL give mem_addr=4, mem_be=0100, mem_wdata=ABABABAB; sh @6 with 0x1234 SHALL give mem_be=1100, mem_wdata=12341234.
REQ-030 Contention test: if_req and d_req rising together in IDLE SHALL give d_gnt at cycle 0, d_rvalid at cycle 1, and if_gnt at cycle 2.
REQ-031 Starvation test: with STARVE_MAX=2 and both requests held continuously, the grant order SHALL be D, D, IF, D, D, IF.
REQ-032 Misalignment test: lw @6 SHALL give, with the macro, d_err=1 and mem_en=0; without the macro, mem_addr=4 and d_err=0.
REQ-033 Reset test: reset asserted in the RESP_D cycle SHALL produce no d_rvalid, and all outputs SHALL be 0 in the following cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared states, RV32 load/store funct3 codes and access helpers for mem_arbiter
package mem_arb_pkg;

  // Arbiter states: grants only happen in IDLE, each RESP state lasts one cycle
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } arb_state_t;

  // RV32 load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access width implied by funct3; unknown codes behave as words
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  function automatic acc_size_t f3_size(input logic [2:0] f3);
    acc_size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      default:     sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // True when the low address bits do not suit the access width
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3_size(f3))
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and single-port memory signals shared by the arbiter and its clients
interface mem_arbiter_if;

  // Instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  // Data load/store port
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic        d_err;
  logic [31:0] d_rdata;

  // Single-port memory command and read data
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Requesters and memory model side
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_funct3, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_err, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_funct3, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_err, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_ls_align.sv
// rtl/mem_arbiter_ls_align.sv - ls_align: store byte-enable/replication and load lane extraction/extension
module ls_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_addr,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: pick lanes and replicate the datum so every lane carries it
  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_wdata;
    case (f3_size(i_st_funct3))
      SZ_BYTE: begin
        o_st_be    = 4'b0001 << i_st_addr;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_st_be    = i_st_addr[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      default: begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
      end
    endcase
  end

  // Load side: select the addressed byte/half lane of the returned word
  always_comb begin
    w_byte = i_ld_rdata[7:0];
    case (i_ld_addr)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_addr[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
  end

  // Load side: sign- or zero-extend the selected lane
  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'h000000, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'h0000, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one memory port with starvation guard; option MISALIGN_CHK_EN
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic             r_we;
  logic             r_err;

  logic             w_grant_if;
  logic             w_grant_d;
  logic             w_misalign;
  logic [3:0]       w_st_be;
  logic [31:0]      w_st_wdata;
  logic [31:0]      w_ld_data;
  logic             w_unused_if_addr;

  // Fetches are always word reads, so the low fetch address bits carry no information
  assign w_unused_if_addr = ^bus.if_addr[1:0];

`ifdef MISALIGN_CHK_EN
  assign w_misalign = is_misaligned(bus.d_funct3, bus.d_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  ls_align u_ls_align (
    .i_st_funct3 (bus.d_funct3),
    .i_st_addr   (bus.d_addr[1:0]),
    .i_st_wdata  (bus.d_wdata),
    .o_st_be     (w_st_be),
    .o_st_wdata  (w_st_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_addr   (r_addr_lo),
    .i_ld_rdata  (bus.mem_rdata),
    .o_ld_data   (w_ld_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration and next state: data wins unless the fetch has waited STARVE_MAX grants
  always_comb begin
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    w_next_state = IDLE;
    case (r_state)
      IDLE: begin
        if (!reset) begin
          if (bus.if_req && (r_starve_cnt == STARVE_LIM)) begin
            w_grant_if = 1'b1;
          end else if (bus.d_req) begin
            w_grant_d = 1'b1;
          end else if (bus.if_req) begin
            w_grant_if = 1'b1;
          end
        end
        if (w_grant_if) begin
          w_next_state = RESP_IF;
        end else if (w_grant_d) begin
          w_next_state = RESP_D;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Count data grants that overtake a waiting fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!bus.if_req || w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Remember the data access shape for formatting the response a cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_grant_d) begin
      r_funct3  <= bus.d_funct3;
      r_addr_lo <= bus.d_addr[1:0];
      r_we      <= bus.d_we;
      r_err     <= w_misalign;
    end
  end

  // Grants and memory command in IDLE, response pulses in the RESP states
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = 32'h0;
    bus.d_gnt     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_err     = 1'b0;
    bus.d_rdata   = 32'h0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;

    if (w_grant_if) begin
      bus.if_gnt   = 1'b1;
      bus.mem_en   = 1'b1;
      bus.mem_be   = 4'b1111;
      bus.mem_addr = {bus.if_addr[31:2], 2'b00};
    end else if (w_grant_d) begin
      bus.d_gnt = 1'b1;
      if (!w_misalign) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.d_we;
        bus.mem_be    = bus.d_we ? w_st_be : 4'b1111;
        bus.mem_addr  = {bus.d_addr[31:2], 2'b00};
        bus.mem_wdata = bus.d_we ? w_st_wdata : 32'h0;
      end
    end

    if ((r_state == RESP_IF) && !reset) begin
      bus.if_rvalid = 1'b1;
      bus.if_rdata  = bus.mem_rdata;
    end

    if ((r_state == RESP_D) && !reset) begin
      bus.d_rvalid = 1'b1;
      bus.d_rdata  = (r_we || r_err) ? 32'h0 : w_ld_data;
`ifdef MISALIGN_CHK_EN
      bus.d_err    = r_err;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (honours MISALIGN_CHK_EN)
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] mem [0:15];
  logic        any_out;
  logic [5:0]  starve_exp;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign any_out = |{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
                     bus.d_err, bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_be,
                     bus.mem_addr, bus.mem_wdata};

  // Memory model: one-cycle read latency, byte-enabled writes, preset contents on reset
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h11223344;
      mem[1] <= 32'h8040F0FF;
      mem[2] <= 32'hCAFEBABE;
      bus.mem_rdata <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      bus.mem_rdata <= mem[bus.mem_addr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_funct3 = f3;
    bus.d_addr   = addr;
    @(negedge clk);
    check({tag, "_gnt"}, bus.d_gnt, 1);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check({tag, "_rvalid"}, bus.d_rvalid, 1);
    check({tag, "_rdata"}, bus.d_rdata, exp);
    next_cycle();
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_funct3 = f3;
    bus.d_addr   = addr;
    bus.d_wdata  = wdata;
    @(negedge clk);
    check({tag, "_mem_we"}, bus.mem_we, 1);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'h4);
    check({tag, "_mem_be"}, bus.mem_be, exp_be);
    check({tag, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
    next_cycle();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    check({tag, "_ack"}, bus.d_rvalid, 1);
    check({tag, "_ack_rdata"}, bus.d_rdata, 0);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    n_checks = 0;
    n_errors = 0;
    reset        = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_funct3 = 3'b000;
    bus.d_addr   = 32'h0;
    bus.d_wdata  = 32'h0;

    // Reset state and idle outputs
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_outs", any_out, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("idle_outs", any_out, 0);
    next_cycle();

    // Loads from word 4 = 8040F0FF
    do_load("lb4",  F3_B,  32'h4, 32'hFFFFFFFF);
    do_load("lbu4", F3_BU, 32'h4, 32'h000000FF);
    do_load("lh4",  F3_H,  32'h4, 32'hFFFFF0FF);
    do_load("lhu4", F3_HU, 32'h4, 32'h0000F0FF);
    do_load("lw4",  F3_W,  32'h4, 32'h8040F0FF);
    do_load("lb7",  F3_B,  32'h7, 32'hFFFFFF80);

    // Stores and read-back of the merged word
    do_store("sb6", F3_B, 32'h6, 32'h000000AB, 4'b0100, 32'hABABABAB);
    do_store("sh6", F3_H, 32'h6, 32'h00001234, 4'b1100, 32'h12341234);
    do_load("lw4_after_st", F3_W, 32'h4, 32'h1234F0FF);

    // Contention: both requests rise together
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000000B;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_funct3 = F3_W;
    bus.d_addr   = 32'h0;
    @(negedge clk);
    check("cont_c0_dgnt", bus.d_gnt, 1);
    check("cont_c0_ifgnt", bus.if_gnt, 0);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check("cont_c1_drvalid", bus.d_rvalid, 1);
    check("cont_c1_drdata", bus.d_rdata, 32'h11223344);
    check("cont_c1_ifgnt", bus.if_gnt, 0);
    next_cycle();
    @(negedge clk);
    check("cont_c2_ifgnt", bus.if_gnt, 1);
    check("cont_c2_mem_addr", bus.mem_addr, 32'h8);
    check("cont_c2_mem_be", bus.mem_be, 4'b1111);
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clk);
    check("cont_c3_ifrvalid", bus.if_rvalid, 1);
    check("cont_c3_ifrdata", bus.if_rdata, 32'hCAFEBABE);
    next_cycle();

    // Starvation with STARVE_MAX=2: D, D, IF, D, D, IF (bit set = fetch)
    starve_exp   = 6'b100100;
    g            = 0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h8;
    bus.d_req    = 1'b1;
    bus.d_funct3 = F3_W;
    bus.d_addr   = 32'h0;
    for (int c = 0; c < 16 && g < 6; c++) begin
      @(negedge clk);
      if (bus.d_gnt || bus.if_gnt) begin
        check($sformatf("starve_grant%0d", g), bus.if_gnt, starve_exp[g]);
        g++;
      end
      next_cycle();
    end
    check("starve_grant_count", g, 6);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    next_cycle();

    // Misaligned word load
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_funct3 = F3_W;
    bus.d_addr   = 32'h6;
    @(negedge clk);
    check("mis_gnt", bus.d_gnt, 1);
`ifdef MISALIGN_CHK_EN
    check("mis_mem_en", bus.mem_en, 0);
`else
    check("mis_mem_en", bus.mem_en, 1);
    check("mis_mem_addr", bus.mem_addr, 32'h4);
`endif
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check("mis_rvalid", bus.d_rvalid, 1);
`ifdef MISALIGN_CHK_EN
    check("mis_err", bus.d_err, 1);
    check("mis_rdata", bus.d_rdata, 0);
`else
    check("mis_err", bus.d_err, 0);
    check("mis_rdata", bus.d_rdata, 32'h1234F0FF);
`endif
    next_cycle();

    // Reset asserted during RESP_D drops the response
    bus.d_req    = 1'b1;
    bus.d_funct3 = F3_W;
    bus.d_addr   = 32'h4;
    @(negedge clk);
    check("rst_resp_gnt", bus.d_gnt, 1);
    next_cycle();
    bus.d_req = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("rst_resp_rvalid", bus.d_rvalid, 0);
    check("rst_resp_outs", any_out, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_rvalid", bus.d_rvalid, 0);
    check("rst_after_outs", any_out, 0);
    next_cycle();

    // Normal operation resumes after reset
    do_load("lbu5_post_rst", F3_BU, 32'h5, 32'h000000F0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
